// File: rtl/rv2t_mm_reg_fifo.sv
// rv2t_mm_reg_fifo: RV2T memory-mapped registers for UART TX, machine timer and GPIO output.
// Define RV2T_MM_REG_TX_FIFO_EN to buffer UART writes in a TX FIFO drained by a small FSM.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif
`ifndef UART_TX_ADDR
`define UART_TX_ADDR 8'h04
`endif
`ifndef MTIMECMP_LOW_ADDR
`define MTIMECMP_LOW_ADDR 8'h02
`endif
`ifndef MTIMECMP_HIGH_ADDR
`define MTIMECMP_HIGH_ADDR 8'h03
`endif

module rv2t_mm_reg_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int GPIO_WIDTH = 8,
    parameter logic [`MM_REG_ADDR_BITS-1:0] UART_STATUS_ADDR = `UART_TX_ADDR + 1'b1,
    parameter logic [`MM_REG_ADDR_BITS-1:0] GPIO_OUT_ADDR    = `UART_TX_ADDR + 2'd2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sync_reset,
    input  logic                         data_read_enable,
    input  logic                         data_write_enable,
    input  logic [`MM_REG_ADDR_BITS-1:0] data_rw_addr,
    input  logic [`XLEN-1:0]             data_write_word,
    output logic                         start_TX,
    output logic [7:0]                   tx_data,
    input  logic                         tx_active,
    output logic [GPIO_WIDTH-1:0]        gpio_out,
    output logic                         enable_out,
    output logic [`XLEN-1:0]             word_out,
    output logic                         timer_triggered,
    output logic                         tx_irq
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_params
        $error("rv2t_mm_reg_fifo: unsupported FIFO_DEPTH or GPIO_WIDTH");
    end

    logic                         wr_tx;
    logic                         wr_gpio;
    logic                         wr_cmp_low;
    logic                         wr_cmp_high;
    logic                         read_q;
    logic [`MM_REG_ADDR_BITS-1:0] addr_q;
    logic [`XLEN-1:0]             status_word;
    logic [`XLEN-1:0]             timer_word;
    logic [63:0]                  mtime;
    logic [63:0]                  mtimecmp;

    assign wr_tx       = data_write_enable && (data_rw_addr == `UART_TX_ADDR);
    assign wr_gpio     = data_write_enable && (data_rw_addr == GPIO_OUT_ADDR);
    assign wr_cmp_low  = data_write_enable && (data_rw_addr == `MTIMECMP_LOW_ADDR);
    assign wr_cmp_high = data_write_enable && (data_rw_addr == `MTIMECMP_HIGH_ADDR);

    // The read address is captured at the strobe; data is muxed from live contents next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_out <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            enable_out <= data_read_enable || data_write_enable;
            read_q     <= data_read_enable;
            if (data_read_enable) addr_q <= data_rw_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         gpio_out <= '0;
        else if (sync_reset)  gpio_out <= '0;
        else if (wr_gpio)     gpio_out <= data_write_word[GPIO_WIDTH-1:0];
    end

    // Machine timer: mtimecmp resets to all ones so the compare cannot hit before firmware sets it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime           <= '0;
            mtimecmp        <= '1;
            timer_triggered <= 1'b0;
        end else if (sync_reset) begin
            mtime           <= '0;
            mtimecmp        <= '1;
            timer_triggered <= 1'b0;
        end else begin
            mtime           <= mtime + 64'd1;
            timer_triggered <= (mtime >= mtimecmp);
            if (wr_cmp_low)  mtimecmp[31:0]  <= data_write_word;
            if (wr_cmp_high) mtimecmp[63:32] <= data_write_word;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    timer_word = mtime[31:0];
            2'd1:    timer_word = mtime[63:32];
            2'd2:    timer_word = mtimecmp[31:0];
            default: timer_word = mtimecmp[63:32];
        endcase
    end

`ifdef RV2T_MM_REG_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACT, WAIT_DONE} tx_state_t;

    tx_state_t     state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;
    logic          wr_stat;
    logic          full;
    logic          push;
    logic          pop;
    logic          flush;
    logic          busy;

    assign wr_stat = data_write_enable && (data_rw_addr == UART_STATUS_ADDR);
    assign full    = (count == DEPTH_C);
    assign push    = wr_tx && !full;
    assign pop     = (state == IDLE) && (count != '0) && !tx_active;
    assign flush   = wr_stat && data_write_word[0];
    assign busy    = (count != '0) || (state != IDLE) || tx_active;
    assign tx_irq  = (count == '0) && (state == IDLE) && irq_en;

    assign status_word = {busy, full, overflow, irq_en, {(`XLEN-13){1'b0}}, 9'(count)};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_write_word[7:0];
    end

    // Drain FSM plus FIFO bookkeeping; fullness is judged before any same-cycle pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            start_TX <= 1'b0;
            tx_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else if (sync_reset) begin
            state    <= IDLE;
            start_TX <= 1'b0;
            tx_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            start_TX <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    state    <= START;
                    start_TX <= 1'b1;
                    tx_data  <= mem[rd_ptr];
                end
                START:     state <= WAIT_ACT;
                WAIT_ACT:  if (tx_active)  state <= WAIT_DONE;
                WAIT_DONE: if (!tx_active) state <= IDLE;
                default:   state <= IDLE;
            endcase

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (wr_tx && full)                         overflow <= 1'b1;
            else if (wr_stat && data_write_word[29])   overflow <= 1'b0;
            if (wr_stat) irq_en <= data_write_word[28];
        end
    end
`else
    assign start_TX    = wr_tx;
    assign tx_data     = data_write_word[7:0];
    assign tx_irq      = 1'b0;
    assign status_word = {tx_active, {(`XLEN-1){1'b0}}};
`endif

    always_comb begin
        word_out = '0;
        if (read_q) begin
            if (addr_q == `UART_TX_ADDR || addr_q == UART_STATUS_ADDR) word_out = status_word;
            else if (addr_q == GPIO_OUT_ADDR) word_out[GPIO_WIDTH-1:0] = gpio_out;
            else word_out = timer_word;
        end
    end

endmodule

// File: tb/tb_rv2t_mm_reg_fifo.sv
// tb_rv2t_mm_reg_fifo: directed self-checking bench for rv2t_mm_reg_fifo, covering both the
// legacy build and the buffered TX build selected by RV2T_MM_REG_TX_FIFO_EN.
`timescale 1ns/1ps

module tb_rv2t_mm_reg_fifo;

    localparam logic [7:0] TX_ADDR       = 8'h04;
    localparam logic [7:0] STATUS_ADDR   = 8'h05;
    localparam logic [7:0] GPIO_ADDR     = 8'h06;
    localparam logic [7:0] CMP_LO_ADDR   = 8'h02;
    localparam logic [7:0] CMP_HI_ADDR   = 8'h03;
    localparam logic [7:0] UNMAPPED_ADDR = 8'h42;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        data_read_enable = 1'b0;
    logic        data_write_enable = 1'b0;
    logic [7:0]  data_rw_addr = '0;
    logic [31:0] data_write_word = '0;
    logic        start_TX;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic [7:0]  gpio_out;
    logic        enable_out;
    logic [31:0] word_out;
    logic        timer_triggered;
    logic        tx_irq;

    int          compared = 0;
    int          mismatched = 0;
    int          busyLeft = 0;
    bit          uartHold = 1'b0;
    logic [7:0]  emitted[$];
    logic [31:0] rdWord;
    logic        ackSeen;
    logic [7:0]  byteSeen;

    always #5 clk = ~clk;

    rv2t_mm_reg_fifo dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sync_reset        (sync_reset),
        .data_read_enable  (data_read_enable),
        .data_write_enable (data_write_enable),
        .data_rw_addr      (data_rw_addr),
        .data_write_word   (data_write_word),
        .start_TX          (start_TX),
        .tx_data           (tx_data),
        .tx_active         (tx_active),
        .gpio_out          (gpio_out),
        .enable_out        (enable_out),
        .word_out          (word_out),
        .timer_triggered   (timer_triggered),
        .tx_irq            (tx_irq)
    );

    // Every comparison funnels through here so the counters and FAIL lines stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock edge, then a sample point 1ns later where the UART model reacts to start_TX.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busyLeft > 0) busyLeft--;
        if (start_TX) begin
            emitted.push_back(tx_data);
            busyLeft = 10;
        end
        tx_active = uartHold || (busyLeft != 0);
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] addr, input logic [31:0] data);
        data_read_enable  = rd;
        data_write_enable = wr;
        data_rw_addr      = addr;
        data_write_word   = data;
        tick();
        ackSeen = enable_out;
        rdWord  = word_out;
        data_read_enable  = 1'b0;
        data_write_enable = 1'b0;
    endtask

    task automatic waitUartIdle(input string tag);
        int n = 0;
        while (tx_active && n < 200) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, tx_active}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values of every output.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_start_TX", {31'd0, start_TX}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        checkOutput("rst_enable_out", {31'd0, enable_out}, 32'd0);
        checkOutput("rst_word_out", word_out, 32'd0);
        checkOutput("rst_tx_irq", {31'd0, tx_irq}, 32'd0);
        checkOutput("rst_timer", {31'd0, timer_triggered}, 32'd0);
        reset_n = 1'b1;
        tick();

`ifdef RV2T_MM_REG_TX_FIFO_EN
        // First byte: start_TX two cycles after the push, status busy until the UART finishes.
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0041);
        checkOutput("ack_write", {31'd0, ackSeen}, 32'd1);
        checkOutput("no_start_plus1", {31'd0, start_TX}, 32'd0);
        tick();
        checkOutput("start_plus2", {31'd0, start_TX}, 32'd1);
        checkOutput("tx_data_41", {24'd0, tx_data}, 32'h41);
        tick();
        checkOutput("start_one_cycle", {31'd0, start_TX}, 32'd0);
        applyStimulus(1'b1, 1'b0, TX_ADDR, 32'd0);
        checkOutput("busy_while_active", rdWord, 32'h8000_0000);
        waitUartIdle("first_byte_done");
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("idle_status", rdWord, 32'h0000_0000);

        // Fill past depth while the UART is held busy.
        uartHold  = 1'b1;
        tx_active = 1'b1;
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, TX_ADDR, i);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("full_overflow_status", rdWord, 32'hE000_0008);

        // Release the UART and write in the very cycle the head is popped: write is dropped.
        uartHold  = 1'b0;
        tx_active = 1'b0;
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0099);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("drop_while_pop", rdWord, 32'hA000_0007);
        applyStimulus(1'b0, 1'b1, STATUS_ADDR, 32'h2000_0000);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("overflow_cleared", rdWord, 32'h8000_0007);

        for (int n = 0; n < 400 && emitted.size() < 9; n++) tick();
        checkOutput("drain_count", emitted.size(), 32'd9);
        waitUartIdle("drain_idle");
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("drained_status", rdWord, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            byteSeen = (emitted.size() > i + 1) ? emitted[i + 1] : 8'hXX;
            checkOutput($sformatf("drain_byte%0d", i), {24'd0, byteSeen}, i);
        end

        // Interrupt: high only when empty, idle and enabled.
        applyStimulus(1'b0, 1'b1, STATUS_ADDR, 32'h1000_0000);
        checkOutput("irq_idle_empty", {31'd0, tx_irq}, 32'd1);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_00A1);
        checkOutput("irq_low_pending", {31'd0, tx_irq}, 32'd0);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_00A2);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_00A3);
        for (int n = 0; n < 300 && !tx_irq; n++) tick();
        checkOutput("irq_rises", {31'd0, tx_irq}, 32'd1);
        checkOutput("irq_after_third", emitted.size(), 32'd12);
        checkOutput("irq_uart_idle", {31'd0, tx_active}, 32'd0);
        byteSeen = (emitted.size() > 11) ? emitted[11] : 8'hXX;
        checkOutput("third_byte", {24'd0, byteSeen}, 32'hA3);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("status_irq_en", rdWord, 32'h1000_0000);
`else
        // Legacy: start_TX and tx_data follow the write combinationally.
        data_write_enable = 1'b1;
        data_rw_addr      = TX_ADDR;
        data_write_word   = 32'h0000_0041;
        #1;
        checkOutput("legacy_start_same_cycle", {31'd0, start_TX}, 32'd1);
        checkOutput("legacy_tx_data", {24'd0, tx_data}, 32'h41);
        tick();
        checkOutput("ack_write", {31'd0, enable_out}, 32'd1);
        data_write_enable = 1'b0;
        #1;
        checkOutput("legacy_start_drops", {31'd0, start_TX}, 32'd0);
        applyStimulus(1'b1, 1'b0, TX_ADDR, 32'd0);
        checkOutput("busy_while_active", rdWord, 32'h8000_0000);
        waitUartIdle("first_byte_done");
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("idle_status", rdWord, 32'h0000_0000);
        checkOutput("legacy_one_start", emitted.size(), 32'd1);
        applyStimulus(1'b0, 1'b1, STATUS_ADDR, 32'h1000_0000);
        checkOutput("legacy_irq_tied", {31'd0, tx_irq}, 32'd0);
`endif

        // GPIO register and its read-back.
        applyStimulus(1'b0, 1'b1, GPIO_ADDR, 32'hFFFF_FFFF);
        checkOutput("gpio_write", {24'd0, gpio_out}, 32'hFF);
        applyStimulus(1'b1, 1'b0, GPIO_ADDR, 32'd0);
        checkOutput("gpio_read", rdWord, 32'h0000_00FF);

`ifdef RV2T_MM_REG_TX_FIFO_EN
        uartHold  = 1'b1;
        tx_active = 1'b1;
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0011);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0022);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("two_queued", rdWord, 32'h9000_0002);
        applyStimulus(1'b0, 1'b1, STATUS_ADDR, 32'h0000_0001);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("flush_status", rdWord, 32'h8000_0000);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0055);
        applyStimulus(1'b0, 1'b1, TX_ADDR, 32'h0000_0066);
`endif

        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        checkOutput("sync_gpio", {24'd0, gpio_out}, 32'd0);

`ifdef RV2T_MM_REG_TX_FIFO_EN
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'd0);
        checkOutput("sync_count", rdWord, 32'h8000_0000);
        uartHold = 1'b0;
        tick();
        checkOutput("no_emit_on_hold", emitted.size(), 32'd12);
`endif

        // Timer: compare of 20 after a sync reset hits when mtime reaches 20.
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        applyStimulus(1'b0, 1'b1, CMP_LO_ADDR, 32'd20);
        applyStimulus(1'b0, 1'b1, CMP_HI_ADDR, 32'd0);
        checkOutput("timer_not_yet", {31'd0, timer_triggered}, 32'd0);
        repeat (18) tick();
        checkOutput("timer_edge_minus1", {31'd0, timer_triggered}, 32'd0);
        tick();
        checkOutput("timer_fires", {31'd0, timer_triggered}, 32'd1);
        applyStimulus(1'b1, 1'b0, CMP_LO_ADDR, 32'd0);
        checkOutput("read_mtimecmp_lo", rdWord, 32'd20);
        applyStimulus(1'b0, 1'b1, UNMAPPED_ADDR, 32'h0000_1234);
        applyStimulus(1'b1, 1'b0, UNMAPPED_ADDR, 32'd0);
        checkOutput("unmapped_read", rdWord, 32'd20);
        tick();
        checkOutput("ack_idle", {31'd0, enable_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
